logic_axi4_stream_packet_buffer: RTL and testbench

// - Single-clock AXI4-Stream store-and-forward packet FIFO; sits directly downstream of

---
 rtl/logic_axi4_stream_packet_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_logic_axi4_stream_packet_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_packet_buffer.sv
// Store-and-forward AXI4-Stream packet FIFO; releases a packet only after its tlast is stored.
// Define LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN to drop oversize packets instead of cutting through.
module logic_axi4_stream_packet_buffer #(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned USE_TLAST   = 1,
  parameter int unsigned USE_TKEEP   = 1,
  parameter int unsigned USE_TSTRB   = 1,
  parameter int unsigned CAPACITY    = 256
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic                         rx_tvalid,
  output logic                         rx_tready,
  input  logic [8*TDATA_BYTES-1:0]     rx_tdata,
  input  logic [TDATA_BYTES-1:0]       rx_tstrb,
  input  logic [TDATA_BYTES-1:0]       rx_tkeep,
  input  logic                         rx_tlast,
  input  logic [TDEST_WIDTH-1:0]       rx_tdest,
  input  logic [TUSER_WIDTH-1:0]       rx_tuser,
  input  logic [TID_WIDTH-1:0]         rx_tid,
  output logic                         tx_tvalid,
  input  logic                         tx_tready,
  output logic [8*TDATA_BYTES-1:0]     tx_tdata,
  output logic [TDATA_BYTES-1:0]       tx_tstrb,
  output logic [TDATA_BYTES-1:0]       tx_tkeep,
  output logic                         tx_tlast,
  output logic [TDEST_WIDTH-1:0]       tx_tdest,
  output logic [TUSER_WIDTH-1:0]       tx_tuser,
  output logic [TID_WIDTH-1:0]         tx_tid,
  output logic [$clog2(CAPACITY):0]    packets,
  output logic                         dropped
);

  localparam int unsigned AW       = $clog2(CAPACITY);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned DW       = 8 * TDATA_BYTES;
  localparam int unsigned OFF_STRB = DW;
  localparam int unsigned OFF_KEEP = OFF_STRB + TDATA_BYTES;
  localparam int unsigned OFF_LAST = OFF_KEEP + TDATA_BYTES;
  localparam int unsigned OFF_DEST = OFF_LAST + 1;
  localparam int unsigned OFF_USER = OFF_DEST + TDEST_WIDTH;
  localparam int unsigned OFF_ID   = OFF_USER + TUSER_WIDTH;
  localparam int unsigned WW       = OFF_ID + TID_WIDTH;

  typedef enum logic [0:0] {StStore, StDrop} state_e;

  logic [WW-1:0] mem [CAPACITY];

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] packets_q, packets_d;
  logic [PW-1:0] limit;
  logic [WW-1:0] rx_word, tx_word_q;
  logic          tx_valid_q, tx_valid_d;
  logic          ready_q;
  logic          rx_last, full, avail, cut_through;
  logic          wr_en, commit, enter_drop, load, deq_last;

  assign rx_last = (USE_TLAST != 0) ? rx_tlast : 1'b1;
  assign rx_word = {rx_tid, rx_tuser, rx_tdest, rx_last, rx_tkeep, rx_tstrb, rx_tdata};
  assign full    = (wr_ptr_q - rd_ptr_q) == PW'(CAPACITY);

`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN
  logic [PW-1:0] beat_cnt_q, beat_cnt_d;
  logic          drop_q, drop_d;

  assign cut_through = 1'b0;
  assign dropped     = drop_q;
`else
  logic ct_q, ct_d;

  // An all-uncommitted full buffer can never commit; drain it up to wr_ptr until tlast lands.
  assign cut_through = ct_q || (full && (packets_q == '0));
  assign dropped     = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= StStore;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN
    unique case (state_q)
      StStore: begin
        if (ready_q && rx_tvalid && !rx_last &&
            (full || (beat_cnt_q == PW'(CAPACITY - 1)))) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (rx_tvalid && rx_last) begin
          state_d = StStore;
        end
      end
      default: state_d = StStore;
    endcase
`else
    state_d = StStore;
`endif
  end

  // FSM outputs
  always_comb begin
    rx_tready  = ready_q && ((state_q == StDrop) || !full);
    wr_en      = rx_tvalid && rx_tready && (state_q == StStore);
    commit     = wr_en && rx_last;
    enter_drop = (state_q == StStore) && (state_d == StDrop);
  end

  // Datapath next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (enter_drop) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    commit_ptr_d = commit ? (wr_ptr_q + 1'b1) : commit_ptr_q;

    limit    = cut_through ? wr_ptr_q : commit_ptr_q;
    avail    = (limit != rd_ptr_q);
    load     = avail && (!tx_valid_q || tx_tready);
    rd_ptr_d = load ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    tx_valid_d = tx_valid_q;
    if (load) begin
      tx_valid_d = 1'b1;
    end else if (tx_tready) begin
      tx_valid_d = 1'b0;
    end

    deq_last  = tx_valid_q && tx_tready && tx_word_q[OFF_LAST];
    packets_d = packets_q + PW'(commit) - PW'(deq_last);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      packets_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_word_q    <= '0;
      ready_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      packets_q    <= packets_d;
      tx_valid_q   <= tx_valid_d;
      ready_q      <= 1'b1;
      if (load) begin
        tx_word_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (enter_drop) begin
      beat_cnt_d = '0;
    end else if (wr_en) begin
      beat_cnt_d = rx_last ? '0 : (beat_cnt_q + 1'b1);
    end
    drop_d = (state_q == StDrop) && rx_tvalid && rx_last;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
    end
  end
`else
  assign ct_d = cut_through && !commit;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ct_q <= 1'b0;
    end else begin
      ct_q <= ct_d;
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= rx_word;
    end
  end

  assign tx_tvalid = tx_valid_q;
  assign tx_tdata  = tx_word_q[DW-1:0];
  assign tx_tstrb  = (USE_TSTRB != 0) ? tx_word_q[OFF_STRB +: TDATA_BYTES] : '1;
  assign tx_tkeep  = (USE_TKEEP != 0) ? tx_word_q[OFF_KEEP +: TDATA_BYTES] : '1;
  assign tx_tlast  = tx_word_q[OFF_LAST];
  assign tx_tdest  = tx_word_q[OFF_DEST +: TDEST_WIDTH];
  assign tx_tuser  = tx_word_q[OFF_USER +: TUSER_WIDTH];
  assign tx_tid    = tx_word_q[OFF_ID +: TID_WIDTH];
  assign packets   = packets_q;

endmodule

// File: tb/tb_logic_axi4_stream_packet_buffer.sv
// Scoreboard bench for logic_axi4_stream_packet_buffer (CAPACITY=8); the expected beat stream is
// the input packets in order, minus packets longer than CAPACITY when dropping is compiled in.
`timescale 1ns/1ps
module tb_logic_axi4_stream_packet_buffer;

  localparam int unsigned CAP = 8;

  logic       aclk = 1'b0;
  logic       areset_n = 1'b0;
  logic       rx_tvalid, rx_tready;
  logic [7:0] rx_tdata;
  logic       rx_tstrb, rx_tkeep, rx_tlast, rx_tdest, rx_tuser, rx_tid;
  logic       tx_tvalid, tx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tstrb, tx_tkeep, tx_tlast, tx_tdest, tx_tuser, tx_tid;
  logic [3:0] packets;
  logic       dropped;

  always #5 aclk = ~aclk;

  logic_axi4_stream_packet_buffer #(
    .TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1), .CAPACITY(CAP)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb),
    .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
    .rx_tid(rx_tid),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tdest(tx_tdest), .tx_tuser(tx_tuser),
    .tx_tid(tx_tid),
    .packets(packets), .dropped(dropped)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] exp_q[$];
  int          drops_seen = 0;
  bit          big_active = 0, tlast_done = 0, early_valid = 0;
  bit          t4_done = 0;
  logic [13:0] prev_word;
  logic        prev_valid = 0, prev_ready = 0;
  logic [13:0] txw;

  assign txw = {tx_tid, tx_tuser, tx_tdest, tx_tlast, tx_tkeep, tx_tstrb, tx_tdata};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every tx handshake and checks hold-while-stalled.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge aclk);
      if (areset_n) begin
        if (prev_valid && !prev_ready) check("tx_hold", {tx_tvalid, txw}, {1'b1, prev_word});
        if (tx_tvalid && tx_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_unexpected: got 0x%0h, expected no beat", txw);
          end else begin
            e = exp_q.pop_front();
            check("tx_beat", txw, e);
          end
        end
        if (dropped) drops_seen++;
        if (big_active && !tlast_done && tx_tvalid) early_valid = 1;
      end
      prev_valid = tx_tvalid && areset_n;
      prev_word  = txw;
      prev_ready = tx_tready;
    end
  end

  task automatic send_beat(input logic [13:0] w);
    bit ok = 0;
    {rx_tid, rx_tuser, rx_tdest, rx_tlast, rx_tkeep, rx_tstrb, rx_tdata} = w;
    rx_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (rx_tready) begin
        @(posedge aclk);
        #1;
        ok = 1;
        break;
      end
    end
    rx_tvalid = 1'b0;
    if (w[10]) tlast_done = 1;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_timeout: got no rx_tready, expected handshake");
    end
  endtask

  // base != 0 gives data base*(j+1); otherwise data is random. Side fields are always random.
  task automatic send_pkt(input int len, input logic [7:0] base);
    logic [13:0] beats[$];
    bit          keep_pkt = 1;
    logic [7:0]  d;
`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN
    if (len > CAP) keep_pkt = 0;
`endif
    for (int j = 0; j < len; j++) begin
      d = (base != 0) ? 8'(base * (j + 1)) : 8'($urandom_range(0, 255));
      beats.push_back({3'($urandom_range(0, 7)), (j == len - 1), 2'($urandom_range(0, 3)), d});
    end
    if (keep_pkt) foreach (beats[k]) exp_q.push_back(beats[k]);
    foreach (beats[k]) send_beat(beats[k]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && !tx_tvalid) break;
      @(posedge aclk);
      #1;
    end
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_tvalid_low"}, tx_tvalid, 0);
    check({name, "_packets_zero"}, packets, 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    rx_tvalid = 0; rx_tdata = 0; rx_tstrb = 0; rx_tkeep = 0; rx_tlast = 0;
    rx_tdest = 0; rx_tuser = 0; rx_tid = 0; tx_tready = 0;

    // Reset state
    step(3);
    check("rst_tvalid", tx_tvalid, 0);
    check("rst_packets", packets, 0);
    check("rst_dropped", dropped, 0);
    check("rst_tready_in_reset", rx_tready, 0);
    areset_n = 1'b1;
    #1;
    check("rst_tready_at_release", rx_tready, 0);
    step(1);
    check("rst_tready_after_1", rx_tready, 1);

    // 4-beat packet, latency and packet count
    tx_tready = 1'b1;
    send_pkt(4, 8'h11);
    check("t2_tvalid_cycle1", tx_tvalid, 0);
    check("t2_packets_commit", packets, 1);
    step(1);
    check("t2_tvalid_cycle2", tx_tvalid, 1);
    check("t2_first_data", tx_tdata, 8'h11);
    drain("t2");

    // Three packets while stalled, then contiguous drain
    tx_tready = 1'b0;
    send_pkt(2, 0);
    send_pkt(3, 0);
    send_pkt(1, 0);
    step(2);
    check("t3_packets", packets, 3);
    tx_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check("t3_contiguous", tx_tvalid, 1);
    end
    step(1);
    drain("t3");

    // One-beat packets with random tready across pointer wrap
    t4_done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send_pkt(1, 0);
          step($urandom_range(0, 1));
        end
        t4_done = 1;
      end
      begin
        while (!t4_done) begin
          tx_tready = 1'($urandom_range(0, 1));
          step(1);
        end
      end
    join
    tx_tready = 1'b1;
    drain("t4");

`ifdef LOGIC_AXI4_STREAM_PACKET_BUFFER_DROP_EN
    // Oversize packet dropped, neighbours intact
    drops_seen = 0;
    send_pkt(2, 0);
    send_pkt(12, 0);
    send_pkt(3, 0);
    drain("t5");
    check("t5_drop_pulses", drops_seen, 1);
`else
    // Oversize packet drains by cut-through
    big_active = 1;
    tlast_done = 0;
    early_valid = 0;
    send_pkt(12, 0);
    big_active = 0;
    check("t5_valid_before_tlast", early_valid, 1);
    drain("t5");
    check("t5_no_drops", drops_seen, 0);
`endif

    // Reset mid-packet
    tx_tready = 1'b0;
    send_pkt(1, 0);
    for (int j = 0; j < 3; j++) send_beat({3'b000, 1'b0, 2'b11, 8'(8'hA0 + j)});
    step(1);
    check("t6_packets_pre", packets, 1);
    areset_n = 1'b0;
    #1;
    check("t6_tvalid_reset", tx_tvalid, 0);
    check("t6_packets_reset", packets, 0);
    exp_q.delete();
    step(2);
    areset_n = 1'b1;
    step(2);
    tx_tready = 1'b1;
    send_pkt(2, 8'h21);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
